// File: rtl/rr_channel_mux_pkg.sv
// rr_channel_mux shared definitions.
// Mode encodings for the per-cycle selection port.
package rr_channel_mux_pkg;

  localparam logic MODE_ADDRESSED = 1'b0;
  localparam logic MODE_RR        = 1'b1;

endpackage

// File: rtl/rr_channel_mux_rr_arbiter.sv
// Round-robin arbiter: rotate requests past last_grant,
// then pick the lowest set bit and rotate the index back.
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int SEL_BITS = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] request,
  input  logic [SEL_BITS-1:0] last_grant,
  output logic [SEL_BITS-1:0] grant,
  output logic                grant_valid
);

  localparam int SW = SEL_BITS + 2;
  localparam logic [SW-1:0] CH = SW'(CHANNELS);

  logic [2*CHANNELS-1:0] dbl;
  logic [CHANNELS-1:0]   rot;
  logic [SW-1:0]         start;
  logic [SW-1:0]         pos;
  logic [SW-1:0]         sum;

  always_comb begin
    start = SW'(last_grant) + SW'(1);
    if (start >= CH) start = '0;
    dbl = {request, request};
    rot = dbl[start +: CHANNELS];
    pos = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (rot[i]) pos = SW'(i);
    end
    // pos is relative to start; fold back into 0..CHANNELS-1
    sum = start + pos;
    if (sum >= CH) sum = sum - CH;
    grant       = sum[SEL_BITS-1:0];
    grant_valid = |request;
  end

endmodule

// File: rtl/rr_channel_mux.sv
// N-channel mux with registered output, valid/ready on every side,
// and per-cycle choice of addressed or round-robin selection.
module rr_channel_mux
  import rr_channel_mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_BITS = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_BITS-1:0]       address,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_BITS-1:0]       out_channel,
  input  logic                      out_ready
);

  localparam int NPAD = 1 << SEL_BITS;

  logic [SEL_BITS-1:0] last_q, last_d;
  logic [SEL_BITS-1:0] chan_q, chan_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                valid_q, valid_d;

  logic [SEL_BITS-1:0] rr_grant, grant;
  logic                rr_valid, grant_valid;
  logic                slot_free, xfer;
  logic [NPAD-1:0]     valid_pad;

  rr_arbiter #(
    .CHANNELS(CHANNELS),
    .SEL_BITS(SEL_BITS)
  ) u_arb (
    .request    (in_valid),
    .last_grant (last_q),
    .grant      (rr_grant),
    .grant_valid(rr_valid)
  );

  always_comb begin
    // padding makes out-of-range addresses read as not-valid
    valid_pad = NPAD'(in_valid);
    if (mode == MODE_RR) begin
      grant       = rr_grant;
      grant_valid = rr_valid;
    end else begin
      grant       = address;
      grant_valid = valid_pad[address];
    end

    slot_free = !valid_q || out_ready;
    xfer      = slot_free && grant_valid;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = xfer && (grant == SEL_BITS'(i));
    end

    valid_d = valid_q && !out_ready;
    data_d  = data_q;
    chan_d  = chan_q;
    last_d  = last_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = in_data[int'(grant)*WIDTH +: WIDTH];
      chan_d  = grant;
      if (mode == MODE_RR) last_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      last_q  <= SEL_BITS'(CHANNELS - 1);
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      last_q  <= last_d;
    end
  end

  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign out_channel = chan_q;

endmodule

// File: tb/tb_rr_channel_mux.sv
// Bench for rr_channel_mux: directed vector table, a 3-channel
// invalid-address check, and random traffic against a reference model.
module tb_rr_channel_mux;

  localparam int W  = 32;
  localparam int C  = 4;
  localparam int SB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, mode, out_ready;
  logic [SB-1:0] address;
  logic [C*W-1:0] in_data;
  logic [C-1:0]  in_valid, in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic [SB-1:0] out_channel;

  rr_channel_mux #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .reset(reset), .mode(mode), .address(address),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
    .out_channel(out_channel), .out_ready(out_ready)
  );

  logic          rst3, md3, ordy3, ov3;
  logic [1:0]    addr3, oc3;
  logic [3*W-1:0] idata3;
  logic [2:0]    iv3, ird3;
  logic [W-1:0]  od3;

  rr_channel_mux #(.WIDTH(W), .CHANNELS(3)) dut3 (
    .clk(clk), .reset(rst3), .mode(md3), .address(addr3),
    .in_data(idata3), .in_valid(iv3), .in_ready(ird3),
    .out_data(od3), .out_valid(ov3),
    .out_channel(oc3), .out_ready(ordy3)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       md;
    logic [1:0] addr;
    logic [3:0] vld;
    logic       rdy;
    logic [3:0] erdy;
    logic       eov;
    logic [1:0] ech;
    logic       zd;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic md,
                              input logic [1:0] addr,
                              input logic [3:0] vld, input logic rdy,
                              input logic [3:0] erdy, input logic eov,
                              input logic [1:0] ech, input logic zd);
    vec_t v;
    v.rst = rst; v.md = md; v.addr = addr; v.vld = vld; v.rdy = rdy;
    v.erdy = erdy; v.eov = eov; v.ech = ech; v.zd = zd;
    return v;
  endfunction

  vec_t tbl[24];
  logic [W-1:0] chdata[4];

  // reference model state
  logic          m_ov;
  logic [W-1:0]  m_data;
  logic [SB-1:0] m_ch;
  int            m_ptr;
  logic          mg_v, m_slot;
  logic [SB-1:0] mg;
  logic [3:0]    m_rdy;
  int            idx;
  logic [W-1:0]  exp_d;

  initial begin
    chdata[0] = 32'h1111_0000;
    chdata[1] = 32'h2222_1111;
    chdata[2] = 32'hDEAD_BEEF;
    chdata[3] = 32'h4444_3333;

    tbl[0]  = mk(1, 0, 0, 4'b0000, 1, 4'b0000, 0, 0, 1);
    tbl[1]  = mk(1, 0, 0, 4'b0000, 1, 4'b0000, 0, 0, 1);
    tbl[2]  = mk(0, 0, 2, 4'b1111, 1, 4'b0100, 1, 2, 0);
    tbl[3]  = mk(0, 0, 2, 4'b1111, 1, 4'b0100, 1, 2, 0);
    tbl[4]  = mk(0, 1, 0, 4'b1011, 1, 4'b0001, 1, 0, 0);
    tbl[5]  = mk(0, 1, 0, 4'b1011, 1, 4'b0010, 1, 1, 0);
    tbl[6]  = mk(0, 1, 0, 4'b1011, 1, 4'b1000, 1, 3, 0);
    tbl[7]  = mk(0, 1, 0, 4'b1011, 1, 4'b0001, 1, 0, 0);
    tbl[8]  = mk(0, 1, 0, 4'b1011, 1, 4'b0010, 1, 1, 0);
    tbl[9]  = mk(0, 1, 0, 4'b1011, 1, 4'b1000, 1, 3, 0);
    tbl[10] = mk(0, 1, 0, 4'b1011, 1, 4'b0001, 1, 0, 0);
    tbl[11] = mk(0, 1, 0, 4'b1011, 0, 4'b0000, 1, 0, 0);
    tbl[12] = mk(0, 1, 0, 4'b1011, 0, 4'b0000, 1, 0, 0);
    tbl[13] = mk(0, 1, 0, 4'b1011, 0, 4'b0000, 1, 0, 0);
    tbl[14] = mk(0, 1, 0, 4'b1011, 1, 4'b0010, 1, 1, 0);
    tbl[15] = mk(0, 1, 0, 4'b1011, 0, 4'b0000, 1, 1, 0);
    tbl[16] = mk(1, 1, 0, 4'b1011, 0, 4'b0000, 0, 0, 1);
    tbl[17] = mk(0, 1, 0, 4'b1111, 0, 4'b0001, 1, 0, 0);
    tbl[18] = mk(0, 0, 3, 4'b1111, 1, 4'b1000, 1, 3, 0);
    tbl[19] = mk(0, 1, 0, 4'b1111, 1, 4'b0010, 1, 1, 0);
    tbl[20] = mk(0, 0, 1, 4'b1101, 1, 4'b0000, 0, 1, 0);
    tbl[21] = mk(0, 1, 0, 4'b0100, 1, 4'b0100, 1, 2, 0);
    tbl[22] = mk(0, 1, 0, 4'b0100, 1, 4'b0100, 1, 2, 0);
    tbl[23] = mk(0, 1, 0, 4'b0100, 1, 4'b0100, 1, 2, 0);

    reset = 1'b1; mode = 1'b0; address = '0;
    in_valid = '0; out_ready = 1'b1;
    for (int c = 0; c < C; c++) in_data[c*W +: W] = chdata[c];

    // 3-channel instance: address 3 does not exist
    rst3 = 1'b1; md3 = 1'b0; addr3 = 2'd3; iv3 = 3'b111;
    ordy3 = 1'b1; idata3 = {32'h0000_0333, 32'h0000_0222, 32'h0000_0111};
    repeat (2) @(posedge clk);
    #1 rst3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("c3 bad addr in_ready %0d", k), 32'(ird3), 0);
      @(posedge clk); #1;
      chk($sformatf("c3 bad addr out_valid %0d", k), 32'(ov3), 0);
    end
    addr3 = 2'd2;
    @(negedge clk);
    chk("c3 addr2 in_ready", 32'(ird3), 32'b100);
    @(posedge clk); #1;
    chk("c3 addr2 out_channel", 32'(oc3), 2);
    chk("c3 addr2 out_data", od3, 32'h0000_0333);

    for (int i = 0; i < 24; i++) begin
      reset = tbl[i].rst; mode = tbl[i].md; address = tbl[i].addr;
      in_valid = tbl[i].vld; out_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].erdy));
      @(posedge clk); #1;
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
      chk($sformatf("row%0d out_channel", i), 32'(out_channel),
          32'(tbl[i].ech));
      exp_d = tbl[i].zd ? 32'h0 : chdata[tbl[i].ech];
      chk($sformatf("row%0d out_data", i), out_data, exp_d);
    end

    // random traffic; first cycle is a reset to align the model
    m_ov = 1'b0; m_data = '0; m_ch = '0; m_ptr = C - 1;
    for (int t = 0; t < 400; t++) begin
      reset     = (t == 0) || ($urandom_range(0, 31) == 0);
      mode      = 1'($urandom);
      address   = SB'($urandom);
      in_valid  = C'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < C; c++) in_data[c*W +: W] = $urandom;

      mg_v = 1'b0; mg = '0;
      if (!mode) begin
        mg_v = in_valid[address];
        mg   = address;
      end else begin
        for (int k = 1; k <= C; k++) begin
          idx = (m_ptr + k) % C;
          if (!mg_v && in_valid[idx]) begin
            mg_v = 1'b1;
            mg   = SB'(idx);
          end
        end
      end
      m_slot = !m_ov || out_ready;
      m_rdy  = (m_slot && mg_v) ? (4'b0001 << mg) : 4'b0000;

      @(negedge clk);
      chk($sformatf("rand%0d in_ready", t), 32'(in_ready), 32'(m_rdy));

      if (reset) begin
        m_ov = 1'b0; m_data = '0; m_ch = '0; m_ptr = C - 1;
      end else if (m_slot && mg_v) begin
        m_ov   = 1'b1;
        m_data = in_data[int'(mg)*W +: W];
        m_ch   = mg;
        if (mode) m_ptr = int'(mg);
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end

      @(posedge clk); #1;
      chk($sformatf("rand%0d out_valid", t), 32'(out_valid), 32'(m_ov));
      chk($sformatf("rand%0d out_channel", t), 32'(out_channel), 32'(m_ch));
      chk($sformatf("rand%0d out_data", t), out_data, m_data);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_channel_mux.md
Name: rr_channel_mux

Overview:
- Parametrised N-channel, W-bit multiplexer with a registered output and valid/ready handshaking on every input channel and on the output.
- Selection mode is chosen per cycle by a port:
  - addressed mode: the channel is picked by an address bus, as in earlier mux generations;
  - round-robin mode: the block arbitrates fairly among the requesting channels.
- Sits between multiple producers (ALU result sources, memory/IO return paths) and a single consumer stage in the CPU datapath.

Parameters:
- WIDTH, 32, data width of each channel and of the output.
- CHANNELS, 4, number of input channels; must be ≥ 2.
- SEL_BITS, $clog2(CHANNELS), width of the address and out_channel buses (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = addressed, 1 = round-robin.
- address  input  SEL_BITS  channel select, used in addressed mode only.
- in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel request.
- in_ready  output  CHANNELS  per-channel accept (one-hot or zero).
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_channel  output  SEL_BITS  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the word this cycle.

Behaviour:
- Reset (synchronous, sampled on clk rise):
  - out_valid = 0, out_data = 0, out_channel = 0;
  - rr pointer last_grant = CHANNELS-1, so the first round-robin winner is the lowest requesting index starting at channel 0.
- Slot availability: slot_free = !out_valid | out_ready (combinational). A transfer into the register occurs when slot_free & a grant exists.
- Grant in addressed mode:
  - grant = address when in_valid[address] = 1;
  - no grant when in_valid[address] = 0 or address ≥ CHANNELS (non-power-of-two CHANNELS).
- Grant in round-robin mode: first i with in_valid[i] = 1, scanning last_grant+1, last_grant+2, … modulo CHANNELS, wrapping past CHANNELS-1 to 0.
- in_ready[i] = slot_free & grant_valid & (grant == i). At most one bit is set. in_ready never depends on out_valid/in_valid of other cycles; no combinational path from in_data to out_data.
- On transfer at edge k:
  - out_data <= selected in_data;
  - out_channel <= grant;
  - out_valid <= 1.
  Latency is 1 cycle from acceptance to out_valid.
- On out_valid & out_ready with no new transfer: out_valid <= 0. out_data and out_channel hold their last values.
- Simultaneous pop and push in the same cycle: the register is replaced; full throughput is 1 word/cycle.
- Stall: while out_valid & !out_ready, out_data and out_channel are stable and all in_ready are 0.
- last_grant updates to grant only on a round-robin-mode transfer. Addressed-mode transfers do not touch it.
- A mode change takes effect for the next grant evaluation only; a held output word is unaffected.
- Reset asserted mid-stall discards the held word (out_valid = 0 next cycle) regardless of out_ready.
- Single requester in round-robin mode is granted every cycle it requests, with no bubbles.

Decomposition:
- Shared header (alongside the ALU utility macros):
  - mode encodings MODE_ADDRESSED = 1'b0, MODE_RR = 1'b1;
  - no other typedefs needed.
- Sub-module rr_arbiter:
  - inputs: request[CHANNELS], last_grant[SEL_BITS];
  - outputs: grant[SEL_BITS], grant_valid;
  - purely combinational, rotate-then-priority-encode.
- Top level owns: mode mux of the grant, the output register, the pointer register, and in_ready generation.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, all in_valid = 0 → out_valid = 0, out_data = 0, in_ready = 0.
- Addressed mode, mode=0, address=2, in_valid=4'b1111, in_data ch2 = 32'hDEAD_BEEF, out_ready=1 → next cycle out_data = DEADBEEF, out_channel = 2; in_ready = 4'b0100 every cycle.
- Round-robin fairness, mode=1, in_valid=4'b1011 held, out_ready=1 → out_channel sequence 0, 1, 3, 0, 1, 3; no bubbles.
- Backpressure, out_ready=0 for 3 cycles after the first word:
  - out_data stays constant and in_ready = 0;
  - after out_ready=1, the next word appears one cycle later;
  - the rr pointer advanced only once.
- Invalid address with CHANNELS=3: address=3, all valid → no in_ready, out_valid stays 0.
- Reset mid-stall, out_valid=1, out_ready=0, reset pulsed 1 cycle → out_valid = 0; the next round-robin grant goes to channel 0.
